// File: rtl/ahb_lite_slave_mem_if.sv
// AHB-Lite bus bundle between a single master and ahb_lite_slave_mem.
// Clock and reset stay outside the bundle as plain ports.
interface ahb_lite_slave_mem_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TRANS_WIDTH = 2,
  parameter int SIZE_WIDTH  = 3,
  parameter int BURST_WIDTH = 3,
  parameter int PROT_WIDTH  = 4,
  parameter int RESP_WIDTH  = 1,
  parameter int READY_WIDTH = 1
);
  logic                   HSEL;
  logic                   HWRITE;
  logic [TRANS_WIDTH-1:0] HTRANS;
  logic [SIZE_WIDTH-1:0]  HSIZE;
  logic [BURST_WIDTH-1:0] HBURST;
  logic [PROT_WIDTH-1:0]  HPROT;
  logic [ADDR_WIDTH-1:0]  HADDR;
  logic [DATA_WIDTH-1:0]  HWDATA;
  logic [DATA_WIDTH-1:0]  HRDATA;
  logic [RESP_WIDTH-1:0]  HRESP;
  logic [READY_WIDTH-1:0] HREADY;

  modport master (
    output HSEL, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    input  HRDATA, HRESP, HREADY
  );

  modport slave (
    input  HSEL, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HADDR, HWDATA,
    output HRDATA, HRESP, HREADY
  );
endinterface

// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave backed by a MEM_DEPTH x 32-bit register array, little-endian lanes.
// Optional macro AHB_WAIT_STATE_EN inserts one HREADY=0 cycle before every legal completion.
module ahb_lite_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16
) (
  input  logic                clk,
  input  logic                HRESETn,
  ahb_lite_slave_mem_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  function automatic logic [3:0] lane_mask(input logic [1:0] offs, input logic [1:0] size);
    logic [3:0] m;
    case (size)
      2'd0:    m = 4'b0001 << offs;
      2'd1:    m = offs[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  logic [2:0]            state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  resp_q, resp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  dp_write_q, dp_write_d;
  logic [IDX_W-1:0]      dp_idx_q, dp_idx_d;
  logic [3:0]            dp_lane_q, dp_lane_d;
  logic [31:0]           mem_q [MEM_DEPTH];
  logic [31:0]           mem_d [MEM_DEPTH];

  logic cap_s;
  logic legal_s;
  logic commit_s;
  logic unused_s;

  assign cap_s    = bus.HSEL && ready_q && bus.HTRANS[1];
  assign commit_s = (state_q == ST_DATA) && dp_write_q;
  assign unused_s = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

  assign bus.HREADY = ready_q;
  assign bus.HRESP  = resp_q;
  assign bus.HRDATA = rdata_q;

  // Legality of the transfer currently presented in the address phase
  always_comb begin
    if (bus.HSIZE > 3'd2) begin
      legal_s = 1'b0;
    end else if ((bus.HSIZE == 3'd1) && bus.HADDR[0]) begin
      legal_s = 1'b0;
    end else if ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00)) begin
      legal_s = 1'b0;
    end else if (bus.HADDR >= MEM_BYTES) begin
      legal_s = 1'b0;
    end else begin
      legal_s = 1'b1;
    end
  end

  // Next memory image; reads sample this so a same-edge write commit is forwarded
  always_comb begin
    mem_d = mem_q;
    if (commit_s) begin
      for (int b = 0; b < 4; b++) begin
        mem_d[dp_idx_q][8*b +: 8] = dp_lane_q[b] ? bus.HWDATA[8*b +: 8]
                                                 : mem_q[dp_idx_q][8*b +: 8];
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Data-phase sequencing and response generation
  always_comb begin
    state_d    = ST_IDLE;
    ready_d    = 1'b1;
    resp_d     = 1'b0;
    rdata_d    = {DATA_WIDTH{1'b0}};
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_lane_d  = dp_lane_q;
    case (state_q)
      ST_WAIT: begin
        state_d = ST_DATA;
        rdata_d = dp_write_q ? {DATA_WIDTH{1'b0}} : mem_d[dp_idx_q];
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
        resp_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Capture only happens while HREADY=1, i.e. never in ST_WAIT or ST_ERR1
    if (cap_s) begin
      dp_write_d = bus.HWRITE;
      dp_idx_d   = bus.HADDR[IDX_W+1:2];
      dp_lane_d  = lane_mask(bus.HADDR[1:0], bus.HSIZE[1:0]);
      if (!legal_s) begin
        state_d = ST_ERR1;
        ready_d = 1'b0;
        resp_d  = 1'b1;
      end else begin
`ifdef AHB_WAIT_STATE_EN
        state_d = ST_WAIT;
        ready_d = 1'b0;
`else
        state_d = ST_DATA;
        rdata_d = bus.HWRITE ? {DATA_WIDTH{1'b0}} : mem_d[bus.HADDR[IDX_W+1:2]];
`endif
      end
    end else begin
      dp_write_d = dp_write_q;
    end
  end

  // State, response and memory registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      resp_q     <= 1'b0;
      rdata_q    <= {DATA_WIDTH{1'b0}};
      dp_write_q <= 1'b0;
      dp_idx_q   <= {IDX_W{1'b0}};
      dp_lane_q  <= 4'b0000;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_lane_q  <= dp_lane_d;
      mem_q      <= mem_d;
    end
  end
endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Scoreboard bench for ahb_lite_slave_mem: driver queues expected responses,
// a negedge monitor pops and compares them as data phases complete.
module tb_ahb_lite_slave_mem;
`ifdef AHB_WAIT_STATE_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic clk = 1'b0;
  logic HRESETn = 1'b0;
  always #5 clk = ~clk;

  ahb_lite_slave_mem_if bus ();

  ahb_lite_slave_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH (16)
  ) dut (
    .clk    (clk),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  typedef struct {
    string       nm;
    bit          is_read;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for HREADY=1 and step past the capturing edge
  task automatic wait_accept(input string nm);
    int k = 0;
    @(negedge clk);
    while (bus.HREADY !== 1'b1 && k < 8) begin
      k++;
      @(negedge clk);
    end
    if (bus.HREADY !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept_timeout: HREADY stuck at %b", nm, bus.HREADY);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [31:0] addr,
                      input logic [31:0] wd, input bit err, input logic [31:0] rd,
                      input string nm, input bit push = 1'b1);
    exp_t e;
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'd2;
    bus.HWRITE = wr;
    bus.HSIZE  = sz;
    bus.HADDR  = addr;
    bus.HBURST = 3'd1;
    bus.HPROT  = 4'h3;
    if (push) begin
      e.nm = nm; e.is_read = !wr; e.err = err; e.rdata = rd;
      sb.push_back(e);
    end
    wait_accept(nm);
    bus.HWDATA = wd;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'd0;
  endtask

  // Address phase that must not start a data phase
  task automatic noxfer(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                        input logic [31:0] wd, input string nm);
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HWRITE = 1'b1;
    bus.HSIZE  = 3'd2;
    bus.HADDR  = addr;
    wait_accept(nm);
    bus.HWDATA = wd;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'd0;
  endtask

  task automatic do_reset(input int n);
    HRESETn    = 1'b0;
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'd0;
    repeat (n) @(posedge clk);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic post_reset_chk(input string nm);
    @(negedge clk);
    chk({nm, "_hrdata"}, bus.HRDATA, 32'h0000_0000);
    chk({nm, "_hready"}, 32'(bus.HREADY), 32'd1);
    chk({nm, "_hresp"}, 32'(bus.HRESP), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: tracks data phases from the bus itself and checks each completion
  initial begin : monitor
    bit   dp;
    int   waits;
    exp_t cur;
    dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!HRESETn) begin
        dp = 1'b0;
        waits = 0;
      end else begin
        if (dp) begin
          if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
          end else if (bus.HREADY !== 1'b1) begin
            waits++;
            chk({sb[0].nm, "_wait_resp"}, 32'(bus.HRESP), sb[0].err ? 32'd1 : 32'd0);
          end else begin
            cur = sb.pop_front();
            chk({cur.nm, "_resp"}, 32'(bus.HRESP), cur.err ? 32'd1 : 32'd0);
            chk({cur.nm, "_waits"}, 32'(waits), cur.err ? 32'd1 : 32'(WS));
            if (cur.is_read || cur.err)
              chk({cur.nm, "_rdata"}, bus.HRDATA, cur.err ? 32'h0000_0000 : cur.rdata);
            waits = 0;
          end
        end else begin
          chk("idle_hready", 32'(bus.HREADY), 32'd1);
          chk("idle_hresp", 32'(bus.HRESP), 32'd0);
        end
        if (bus.HREADY === 1'b1) dp = bus.HSEL && bus.HTRANS[1];
      end
    end
  end

  initial begin
    bus.HSEL = 1'b0; bus.HTRANS = 2'd0; bus.HWRITE = 1'b0; bus.HSIZE = 3'd0;
    bus.HBURST = 3'd0; bus.HPROT = 4'h0; bus.HADDR = 32'h0; bus.HWDATA = 32'h0;

    do_reset(2);
    post_reset_chk("reset");
    xfer(1'b0, 3'd2, 32'h00, 32'h0, 1'b0, 32'h0000_0000, "rd00_after_reset");

    xfer(1'b1, 3'd2, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0, "wr08_word");
    xfer(1'b0, 3'd2, 32'h08, 32'h0, 1'b0, 32'hDEAD_BEEF, "rd08_raw");

    xfer(1'b1, 3'd2, 32'h04, 32'h1122_3344, 1'b0, 32'h0, "wr04_word");
    xfer(1'b1, 3'd0, 32'h06, 32'h00AA_0000, 1'b0, 32'h0, "wr06_byte");
    xfer(1'b0, 3'd2, 32'h04, 32'h0, 1'b0, 32'h11AA_3344, "rd04_after_byte");

    xfer(1'b1, 3'd1, 32'h0E, 32'hBEEF_0000, 1'b0, 32'h0, "wr0E_half");
    xfer(1'b0, 3'd1, 32'h0C, 32'h0, 1'b0, 32'hBEEF_0000, "rd0C_half");
    xfer(1'b1, 3'd0, 32'h0D, 32'h0000_5500, 1'b0, 32'h0, "wr0D_byte");
    xfer(1'b0, 3'd2, 32'h0C, 32'h0, 1'b0, 32'hBEEF_5500, "rd0C_word");

    xfer(1'b1, 3'd2, 32'h00, 32'hCAFE_F00D, 1'b0, 32'h0, "wr00_word");
    xfer(1'b0, 3'd2, 32'h40, 32'h0, 1'b1, 32'h0, "rd40_range_err");
    xfer(1'b1, 3'd2, 32'h40, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr40_range_err");
    xfer(1'b0, 3'd2, 32'h00, 32'h0, 1'b0, 32'hCAFE_F00D, "rd00_after_range");
    xfer(1'b1, 3'd2, 32'h3C, 32'h0102_0304, 1'b0, 32'h0, "wr3C_last");
    xfer(1'b0, 3'd2, 32'h3C, 32'h0, 1'b0, 32'h0102_0304, "rd3C_last");

    xfer(1'b1, 3'd2, 32'h02, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr02_misalign");
    xfer(1'b0, 3'd2, 32'h00, 32'h0, 1'b0, 32'hCAFE_F00D, "rd00_after_misalign");
    xfer(1'b0, 3'd1, 32'h01, 32'h0, 1'b1, 32'h0, "rd01_half_misalign");
    xfer(1'b1, 3'd3, 32'h00, 32'hFFFF_FFFF, 1'b1, 32'h0, "wr00_size3");
    xfer(1'b0, 3'd0, 32'h01, 32'h0, 1'b0, 32'hCAFE_F00D, "rd01_byte");

    noxfer(1'b1, 2'd0, 32'h00, 32'h0, "idle_sel");
    noxfer(1'b1, 2'd1, 32'h00, 32'h0, "busy_sel");
    noxfer(1'b0, 2'd2, 32'h00, 32'h0, "nonseq_nosel");
    xfer(1'b0, 3'd2, 32'h00, 32'h0, 1'b0, 32'hCAFE_F00D, "rd00_after_noxfer");

    xfer(1'b1, 3'd2, 32'h10, 32'h5A5A_5A5A, 1'b0, 32'h0, "wr10_word");
    xfer(1'b0, 3'd2, 32'h3C, 32'h0, 1'b0, 32'h0, "rd3C_reset", 1'b0);
    do_reset(1);
    post_reset_chk("midreset");
    xfer(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h0000_0000, "rd10_after_reset");
    xfer(1'b0, 3'd2, 32'h3C, 32'h0, 1'b0, 32'h0000_0000, "rd3C_after_reset");
    xfer(1'b0, 3'd2, 32'h08, 32'h0, 1'b0, 32'h0000_0000, "rd08_after_reset");

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
